// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: op encodings, FSM state enum, captured-request struct,
// default word-index width, and small op-decoding helpers.
package lsu_pkg;

   localparam int LSU_MEM_IDX_W = 8;

   localparam logic [2:0] LSU_OP_B  = 3'b000;
   localparam logic [2:0] LSU_OP_H  = 3'b001;
   localparam logic [2:0] LSU_OP_W  = 3'b010;
   localparam logic [2:0] LSU_OP_BU = 3'b100;
   localparam logic [2:0] LSU_OP_HU = 3'b101;

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} lsu_state_e;

   typedef struct packed {
      logic       store;
      logic [2:0] op;
      logic [1:0] lane;
   } lsu_req_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op == LSU_OP_B)  || (op == LSU_OP_H) || (op == LSU_OP_W) ||
             (op == LSU_OP_BU) || (op == LSU_OP_HU);
   endfunction

   // op[1:0] gives the access size: 00 byte, 01 half, 10 word
   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
      case (op[1:0])
         2'b01:   return lane[0];
         2'b10:   return |lane;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] force_lane(input logic [2:0] op, input logic [1:0] lane);
      case (op[1:0])
         2'b01:   return {lane[1], 1'b0};
         2'b10:   return 2'b00;
         default: return lane;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
// Ports: word  - word read from data memory
//        lane  - byte offset within the word (already aligned for half/word)
//        op    - access op (size in op[1:0], zero-extend in op[2])
//        wdata - right-justified store data
//        ldata - extended load value
//        mword - word with the store lane merged in (wdata for word ops)
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  op,
   input  logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic [31:0] mword
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b     = word[{lane, 3'b000} +: 8];
      h     = lane[1] ? word[31:16] : word[15:0];
      ldata = word;
      mword = wdata;
      case (op[1:0])
         2'b00: begin
            ldata = {{24{~op[2] & b[7]}}, b};
            mword = word;
            mword[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         2'b01: begin
            ldata = {{16{~op[2] & h[15]}}, h};
            mword = word;
            if (lane[1]) mword[31:16] = wdata[15:0];
            else         mword[15:0]  = wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of the word-addressed data memory.
// Converts byte-addressed byte/half/word requests into single-word
// memory reads/writes; sub-word stores are read-modify-write.
// Ports: clk, rst_n (async, active low)
//        req_valid/req_ready/req_store/req_op/req_addr/req_wdata - request
//        resp_valid/resp_rdata/resp_err - one-cycle response
//        mem_read/mem_write/mem_addr/mem_wdata/mem_rdata - data memory
// Build option: LSU_MISALIGN_TRAP_EN - misaligned half/word accesses
// return resp_err instead of having their low address bits forced down.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_IDX_W = LSU_MEM_IDX_W,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   lsu_state_e           state, state_nxt;
   lsu_req_t             req_r;
   logic [MEM_IDX_W-1:0] idx_r;
   logic [31:0]          wdata_r, rdata_r, mword_r;
   logic                 err_r;
   logic                 accept, trap;
   logic [1:0]           lane_in;
   logic [31:0]          ldata, mword;
   logic                 unused_addr;

   assign accept      = req_valid && req_ready;
   // address bits above the word index only wrap the index
   assign unused_addr = ^req_addr[ADDR_W-1:MEM_IDX_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap    = !op_legal(req_op) || misaligned(req_op, req_addr[1:0]);
   assign lane_in = req_addr[1:0];
`else
   assign trap    = !op_legal(req_op);
   assign lane_in = force_lane(req_op, req_addr[1:0]);
`endif

   lsu_lane_align u_align (
      .word  (mem_rdata),
      .lane  (req_r.lane),
      .op    (req_r.op),
      .wdata (wdata_r),
      .ldata (ldata),
      .mword (mword)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) begin
            if (trap)                                state_nxt = ST_RESP;
            else if (req_store && req_op[1:0] == 2'b10) state_nxt = ST_WR;
            else                                     state_nxt = ST_RD;
         end
         ST_RD:   state_nxt = req_r.store ? ST_WR : ST_RESP;
         ST_WR:   state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_r   <= '0;
         idx_r   <= '0;
         wdata_r <= '0;
         rdata_r <= '0;
         mword_r <= '0;
         err_r   <= 1'b0;
      end else begin
         if (accept) begin
            req_r   <= '{store: req_store, op: req_op, lane: lane_in};
            idx_r   <= req_addr[MEM_IDX_W+1:2];
            wdata_r <= req_wdata;
            mword_r <= req_wdata;   // final write data for word stores
            rdata_r <= '0;
            err_r   <= trap;
         end
         // mem_rdata is valid at the edge that ends the read cycle
         if (state == ST_RD) begin
            if (req_r.store) mword_r <= mword;
            else             rdata_r <= ldata;
         end
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign resp_rdata = resp_valid ? rdata_r : 32'h0;
   assign resp_err   = resp_valid & err_r;
   assign mem_read   = (state == ST_RD);
   assign mem_write  = (state == ST_WR);
   assign mem_addr   = 32'(idx_r);
   assign mem_wdata  = mword_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array data memory stub,
// an arithmetic reference model feeding an expectation queue, and a
// monitor that checks every response, its latency and its memory strobes.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   load_store_unit #(.MEM_IDX_W(8), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
      logic [7:0]  idx;
      logic [31:0] wdata;
      int          acc;
   } exp_t;

   exp_t        exq[$];
   logic [31:0] tmem    [256];
   logic [31:0] ref_mem [256];
   logic        do_preload;
   int          cyc = 0;
   int          n_cmp = 0, n_err = 0;
   int          nrd = 0, nwr = 0;
   logic [7:0]  rd_idx, wr_idx;
   logic [31:0] wr_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // data memory stub: combinational read, write at negedge
   assign mem_rdata = tmem[mem_addr[7:0]];
   always @(negedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < 256; i++) tmem[i] <= 32'h0;
         tmem[4] <= 32'h0000_0007;
         tmem[5] <= 32'h7FFF_FFFF;
         tmem[6] <= 32'h8000_0000;
      end else if (mem_write) begin
         tmem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: strobe bookkeeping and response scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         nrd = 0;
         nwr = 0;
      end else begin
         chk("strobe_excl", {31'b0, mem_read & mem_write}, 32'h0);
         if (mem_read)  begin nrd++; rd_idx = mem_addr[7:0]; end
         if (mem_write) begin nwr++; wr_idx = mem_addr[7:0]; wr_data = mem_wdata; end
         if (resp_valid) begin
            if (exq.size() == 0) begin
               chk("unexpected_resp", {31'b0, resp_valid}, 32'h0);
            end else begin
               exp_t e;
               e = exq.pop_front();
               chk("rdata", resp_rdata, e.rdata);
               chk("err", {31'b0, resp_err}, {31'b0, e.err});
               // cycles from accept edge to the edge that samples resp_valid
               chk("latency", cyc - e.acc + 1, e.lat);
               chk("n_read", nrd, e.nrd);
               chk("n_write", nwr, e.nwr);
               if (e.nrd > 0) chk("rd_idx", {24'b0, rd_idx}, {24'b0, e.idx});
               if (e.nwr > 0) begin
                  chk("wr_idx", {24'b0, wr_idx}, {24'b0, e.idx});
                  chk("wr_data", wr_data, e.wdata);
               end
            end
            nrd = 0;
            nwr = 0;
         end
      end
   end

   // reference model: plain byte arithmetic over the word array
   task automatic model(input bit st, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output exp_t e);
      bit          legal, mis;
      int          size;
      logic [31:0] a, mask, v, nw;
      int          sh;
      legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
      size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
      mis   = (addr % size) != 0;
      e = '{rdata: 32'h0, err: 1'b0, lat: 1, nrd: 0, nwr: 0, idx: 8'h0, wdata: 32'h0, acc: 0};
`ifdef LSU_MISALIGN_TRAP_EN
      e.err = !legal || mis;
`else
      e.err = !legal;
`endif
      if (e.err) return;
      a     = addr - (addr % size);
      e.idx = 8'((a / 4) % 256);
      sh    = int'(a % 4) * 8;
      mask  = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 1;
      if (!st) begin
         v = (ref_mem[e.idx] >> sh) & mask;
         if (!op[2] && size < 4 && v[8*size-1]) v = v | ~mask;
         e.rdata = v;
         e.lat = 2; e.nrd = 1;
      end else begin
         nw = (ref_mem[e.idx] & ~(mask << sh)) | ((wd & mask) << sh);
         ref_mem[e.idx] = nw;
         e.wdata = nw;
         e.nwr = 1;
         if (size == 4) e.lat = 2;
         else begin e.lat = 3; e.nrd = 1; end
      end
   endtask

   task automatic issue(input bit st, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd);
      exp_t e;
      int   g;
      g = 0;
      @(negedge clk);
      // junk requests while busy must be ignored
      while (!req_ready && g < 30) begin
         req_valid = 1'($urandom_range(0, 1));
         req_store = 1'($urandom_range(0, 1));
         req_op    = 3'($urandom_range(0, 7));
         req_addr  = $urandom;
         req_wdata = $urandom;
         @(negedge clk);
         g++;
      end
      if (!req_ready) begin
         chk("ready_timeout", {31'b0, req_ready}, 32'h1);
         req_valid = 1'b0;
         return;
      end
      model(st, op, addr, wd, e);
      e.acc = cyc + 1;
      exq.push_back(e);
      req_valid = 1'b1; req_store = st; req_op = op; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
      chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'h0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'h0);
      chk({tag, "_strobes"}, {30'b0, mem_read, mem_write}, 32'h0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; do_preload = 1'b1;
      req_valid = 1'b0; req_store = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      ref_mem[4] = 32'h0000_0007;
      ref_mem[5] = 32'h7FFF_FFFF;
      ref_mem[6] = 32'h8000_0000;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      do_preload = 1'b0;
      rst_n = 1'b1;

      // reset during the write phase of a sub-word store
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_op = 3'd0; req_addr = 32'd17; req_wdata = 32'hAB;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int g = 0; g < 10 && !mem_write; g++) begin
         @(posedge clk);
         #1;
      end
      chk("abort_saw_write", {31'b0, mem_write}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready_after", {31'b0, req_ready}, 32'h1);
      chk("abort_word4", tmem[4], 32'h0000_0007);

      // directed accesses from the plan
      issue(0, 3'd0, 32'd27, 32'h0);           // lb  -> FFFFFF80
      issue(0, 3'd4, 32'd27, 32'h0);           // lbu -> 00000080
      issue(0, 3'd5, 32'd22, 32'h0);           // lhu -> 00007FFF
      issue(0, 3'd1, 32'd24, 32'h0);           // lh  -> 00000000
      issue(0, 3'd2, 32'd21, 32'h0);           // misaligned lw
      issue(1, 3'd0, 32'd17, 32'hAB);          // sb  -> word4 0000AB07
      issue(0, 3'd2, 32'd16, 32'h0);
      issue(1, 3'd2, 32'd20, 32'h1234_5678);   // sw
      issue(0, 3'd2, 32'd20, 32'h0);
      issue(0, 3'd3, 32'd20, 32'h0);           // illegal op
      issue(1, 3'd7, 32'd20, 32'hFFFF_FFFF);   // illegal store: no write
      issue(1, 3'd1, 32'd1023, 32'hBEEF);      // index 255 boundary
      issue(0, 3'd2, 32'hFFFF_FFFC, 32'h0);    // wraps to index 255

      // randomized traffic on a small window, random high address bits
      for (int n = 0; n < 200; n++) begin
         logic [2:0] op;
         logic [31:0] ad;
         if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(0, 7));
         else begin
            case ($urandom_range(0, 4))
               0: op = 3'd0; 1: op = 3'd1; 2: op = 3'd2; 3: op = 3'd4; default: op = 3'd5;
            endcase
         end
         ad = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
         issue(1'($urandom_range(0, 1)), op, ad, $urandom);
      end

      for (int g = 0; g < 20 && exq.size() != 0; g++) @(negedge clk);
      chk("drain_pending", exq.size(), 32'h0);
      @(negedge clk);
      for (int i = 0; i < 256; i++) chk("mem_final", tmem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
